// File: rtl/kmer_part_receiver_pkg.sv
// Shared constants and types for the k-mer part receiver: geometry of a
// k-mer, one-hot base patterns, their 2-bit codes and the receiver states.
package kmer_part_receiver_pkg;

   localparam int KMER_LEN                = 16;
   localparam int EXTENDER_OUT_PART_COUNT = 2;
   localparam int PART_COUNT              = EXTENDER_OUT_PART_COUNT;
   localparam int ONE_HOT_LEN             = 4;
   localparam int BASE_LEN                = 2;
   localparam int INDICE_LEN              = 9;

   localparam int KMER_BITS    = KMER_LEN * BASE_LEN;
   localparam int KMER_BEATS   = KMER_LEN / EXTENDER_OUT_PART_COUNT;
   localparam int BEAT_BITS    = PART_COUNT * BASE_LEN;
   localparam int BEAT_CNT_LEN = $clog2(KMER_BEATS);

   localparam logic [BEAT_CNT_LEN-1:0] LAST_BEAT = BEAT_CNT_LEN'(KMER_BEATS - 1);

   localparam logic [ONE_HOT_LEN-1:0] OH_A = 4'b0001;
   localparam logic [ONE_HOT_LEN-1:0] OH_C = 4'b0010;
   localparam logic [ONE_HOT_LEN-1:0] OH_G = 4'b0100;
   localparam logic [ONE_HOT_LEN-1:0] OH_T = 4'b1000;

   localparam logic [BASE_LEN-1:0] BASE_A = 2'b00;
   localparam logic [BASE_LEN-1:0] BASE_C = 2'b01;
   localparam logic [BASE_LEN-1:0] BASE_G = 2'b10;
   localparam logic [BASE_LEN-1:0] BASE_T = 2'b11;

   typedef enum logic {
      RX_COLLECT,
      RX_DROP
   } kmer_rx_state_e;

endpackage

// File: rtl/kmer_part_receiver_onehot_base_decoder.sv
// Combinational one-hot to 2-bit base decoder; zero or multi-hot inputs
// are reported through legal=0 and yield a don't-care code.
module onehot_base_decoder
   import kmer_part_receiver_pkg::*;
(
   input  logic [ONE_HOT_LEN-1:0] one_hot,
   output logic [BASE_LEN-1:0]    code,
   output logic                   legal
);

   always_comb begin
      code  = BASE_A;
      legal = 1'b1;
      case (one_hot)
         OH_A:    code = BASE_A;
         OH_C:    code = BASE_C;
         OH_G:    code = BASE_G;
         OH_T:    code = BASE_T;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/kmer_part_receiver.sv
// Receive side of the extender stream: decodes one-hot bases, packs a full
// k-mer for the hasher and drops k-mers with bad bases or broken framing.
module kmer_part_receiver
   import kmer_part_receiver_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              part_valid,
   output logic                              part_ready,
   input  logic [PART_COUNT*ONE_HOT_LEN-1:0] part_data,
   input  logic [INDICE_LEN-1:0]             part_index,
   input  logic                              part_last,
   output logic                              kmer_valid,
   input  logic                              kmer_ready,
   output logic [KMER_BITS-1:0]              kmer_data,
   output logic [INDICE_LEN-1:0]             kmer_index,
   output logic                              err_onehot,
   output logic                              err_len
);

   kmer_rx_state_e            state, state_next;
   logic [BEAT_CNT_LEN-1:0]   beat_cnt, beat_cnt_next;
   logic                      bad, bad_next;
   logic [KMER_BITS-1:0]      acc, acc_next;
   logic [INDICE_LEN-1:0]     index_reg;
   logic [BASE_LEN-1:0]       codes [PART_COUNT];
   logic [PART_COUNT-1:0]     legal;
   logic [BEAT_BITS-1:0]      beat_code;
   logic                      beat_illegal;
   logic                      shift, capture, load, set_err_len, set_err_onehot;

   for (genvar p = 0; p < PART_COUNT; p++) begin : g_dec
      onehot_base_decoder u_dec (
         .one_hot (part_data[p*ONE_HOT_LEN +: ONE_HOT_LEN]),
         .code    (codes[p]),
         .legal   (legal[p])
      );
   end

   // The earlier base (lowest input slice) lands in the most significant code slot.
   always_comb begin
      beat_code = '0;
      for (int p = 0; p < PART_COUNT; p++) begin
         beat_code[(PART_COUNT-1-p)*BASE_LEN +: BASE_LEN] = codes[p];
      end
   end

   assign beat_illegal = ~&legal;
   assign acc_next     = {acc[KMER_BITS-BEAT_BITS-1:0], beat_code};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RX_COLLECT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      beat_cnt_next  = beat_cnt;
      bad_next       = bad;
      part_ready     = 1'b1;
      shift          = 1'b0;
      capture        = 1'b0;
      load           = 1'b0;
      set_err_len    = 1'b0;
      set_err_onehot = 1'b0;
      case (state)
         RX_COLLECT: begin
            // Only the final beat needs the output register free.
            part_ready = (beat_cnt != LAST_BEAT) || !kmer_valid || kmer_ready;
            if (part_valid && part_ready) begin
               shift   = 1'b1;
               capture = (beat_cnt == '0);
               if (beat_cnt != LAST_BEAT) begin
                  if (part_last) begin
                     set_err_len   = 1'b1;
                     beat_cnt_next = '0;
                     bad_next      = 1'b0;
                  end else begin
                     beat_cnt_next = beat_cnt + 1'b1;
                     bad_next      = bad | beat_illegal;
                  end
               end else if (part_last) begin
                  beat_cnt_next = '0;
                  bad_next      = 1'b0;
                  if (bad || beat_illegal) begin
                     set_err_onehot = 1'b1;
                  end else begin
                     load = 1'b1;
                  end
               end else begin
                  set_err_len   = 1'b1;
                  beat_cnt_next = '0;
                  bad_next      = 1'b0;
                  state_next    = RX_DROP;
               end
            end
         end
         RX_DROP: begin
            if (part_valid && part_last) begin
               state_next = RX_COLLECT;
            end
         end
         default: state_next = RX_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         bad        <= 1'b0;
         acc        <= '0;
         index_reg  <= '0;
         kmer_valid <= 1'b0;
         kmer_data  <= '0;
         kmer_index <= '0;
         err_len    <= 1'b0;
         err_onehot <= 1'b0;
      end else begin
         beat_cnt   <= beat_cnt_next;
         bad        <= bad_next;
         err_len    <= set_err_len;
         err_onehot <= set_err_onehot;
         if (shift) begin
            acc <= acc_next;
         end
         if (capture) begin
            index_reg <= part_index;
         end
         if (load) begin
            kmer_valid <= 1'b1;
            kmer_data  <= acc_next;
            kmer_index <= index_reg;
         end else if (kmer_ready) begin
            kmer_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kmer_part_receiver.sv
// Self-checking bench: directed scenarios plus random k-mer traffic, compared
// every cycle against a base-list reference model of the receiver.
module tb_kmer_part_receiver;
   import kmer_part_receiver_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        part_valid = 1'b0;
   logic        part_ready;
   logic [7:0]  part_data = '0;
   logic [8:0]  part_index = '0;
   logic        part_last = 1'b0;
   logic        kmer_valid;
   logic        kmer_ready = 1'b1;
   logic [31:0] kmer_data;
   logic [8:0]  kmer_index;
   logic        err_onehot;
   logic        err_len;

   int checks = 0;
   int failures = 0;
   int gap_max = 0;
   bit rand_ready = 1'b0;

   always #5 clk = ~clk;

   kmer_part_receiver dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .part_valid (part_valid),
      .part_ready (part_ready),
      .part_data  (part_data),
      .part_index (part_index),
      .part_last  (part_last),
      .kmer_valid (kmer_valid),
      .kmer_ready (kmer_ready),
      .kmer_data  (kmer_data),
      .kmer_index (kmer_index),
      .err_onehot (err_onehot),
      .err_len    (err_len)
   );

   // Reference model: a list of received bases per k-mer and an output slot.
   bit          m_drop = 1'b0;
   int          m_cnt = 0;
   bit          m_bad = 1'b0;
   logic [8:0]  m_idx = '0;
   logic [1:0]  m_bases [16];
   bit          m_valid = 1'b0;
   logic [31:0] m_data = '0;
   logic [8:0]  m_index = '0;
   bit          m_err_len = 1'b0;
   bit          m_err_oh = 1'b0;
   int          n_err_len = 0;
   int          n_err_oh = 0;
   logic [40:0] delivered [$];

   function automatic bit base_of(input logic [3:0] oh, output logic [1:0] code);
      code = 2'b00;
      for (int b = 0; b < 4; b++) begin
         if (oh == (4'b0001 << b)) begin
            code = 2'(b);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit model_ready();
      return m_drop || (m_cnt != 7) || !m_valid || kmer_ready;
   endfunction

   task automatic checkOutput(input string name, input logic [40:0] actual, input logic [40:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin : model_proc
      bit         rdy;
      bit         l0, l1;
      logic [1:0] c0, c1;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_drop = 1'b0; m_cnt = 0; m_bad = 1'b0; m_valid = 1'b0;
            m_err_len = 1'b0; m_err_oh = 1'b0;
         end else begin
            rdy = model_ready();
            m_err_len = 1'b0;
            m_err_oh  = 1'b0;
            if (m_valid && kmer_ready) begin
               delivered.push_back({m_index, m_data});
               m_valid = 1'b0;
            end
            if (part_valid && rdy) begin
               if (m_drop) begin
                  if (part_last) m_drop = 1'b0;
               end else begin
                  if (m_cnt == 0) m_idx = part_index;
                  l0 = base_of(part_data[3:0], c0);
                  l1 = base_of(part_data[7:4], c1);
                  m_bases[2*m_cnt]   = c0;
                  m_bases[2*m_cnt+1] = c1;
                  if (!(l0 && l1)) m_bad = 1'b1;
                  m_cnt++;
                  if (part_last) begin
                     if (m_cnt < 8) begin
                        m_err_len = 1'b1; n_err_len++;
                     end else if (m_bad) begin
                        m_err_oh = 1'b1; n_err_oh++;
                     end else begin
                        m_valid = 1'b1;
                        m_index = m_idx;
                        m_data  = '0;
                        for (int i = 0; i < 16; i++) m_data = m_data | (32'(m_bases[i]) << (30 - 2*i));
                     end
                     m_cnt = 0; m_bad = 1'b0;
                  end else if (m_cnt == 8) begin
                     m_err_len = 1'b1; n_err_len++;
                     m_drop = 1'b1; m_cnt = 0; m_bad = 1'b0;
                  end
               end
            end
         end
      end
   end

   initial begin : compare_proc
      forever begin
         @(negedge clk);
         checkOutput("part_ready", 41'(part_ready), 41'(model_ready()));
         checkOutput("kmer_valid", 41'(kmer_valid), 41'(m_valid));
         if (m_valid) begin
            checkOutput("kmer_data", 41'(kmer_data), 41'(m_data));
            checkOutput("kmer_index", 41'(kmer_index), 41'(m_index));
         end
         checkOutput("err_len", 41'(err_len), 41'(m_err_len));
         checkOutput("err_onehot", 41'(err_onehot), 41'(m_err_oh));
      end
   end

   initial begin : ready_proc
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) kmer_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Holds one beat until it is handshaken, then idles with garbage on the bus.
   task automatic applyStimulus(input logic [7:0] data, input logic [8:0] idx, input bit last);
      int waited = 0;
      bit taken = 1'b0;
      part_valid = 1'b1;
      part_data  = data;
      part_index = idx;
      part_last  = last;
      while (!taken) begin
         @(negedge clk);
         taken = part_ready;
         @(posedge clk);
         #1;
         waited++;
         if (!taken && waited > 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_timeout: part_ready stuck at %0b, required 1", part_ready);
            taken = 1'b1;
         end
      end
      part_valid = 1'b0;
      part_data  = 8'($urandom);
      part_index = 9'($urandom);
      part_last  = 1'($urandom);
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic sendKmer(input logic [7:0] first, input logic [7:0] rest, input int nbeats,
                           input int bad_beat, input logic [8:0] idx);
      for (int b = 0; b < nbeats; b++) begin
         applyStimulus((b == 0) ? first : ((b == bad_beat) ? 8'h23 : rest),
                       (b == 0) ? idx : 9'($urandom), b == nbeats - 1);
      end
   endtask

   task automatic settle(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expectDelivered(input string name, input logic [40:0] expected);
      checkOutput({name, "_count"}, 41'(delivered.size()), 41'd1);
      if (delivered.size() > 0) checkOutput(name, delivered.pop_front(), expected);
      delivered.delete();
   endtask

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int e_len0, e_oh0, nb;
      logic [7:0] d;
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_part_ready", 41'(part_ready), 41'd1);
      checkOutput("rst_kmer_valid", 41'(kmer_valid), 41'd0);
      checkOutput("rst_kmer_data", 41'(kmer_data), 41'd0);
      checkOutput("rst_kmer_index", 41'(kmer_index), 41'd0);
      checkOutput("rst_err_len", 41'(err_len), 41'd0);
      checkOutput("rst_err_onehot", 41'(err_onehot), 41'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(1);

      sendKmer(8'h21, 8'h21, 8, -1, 9'd37);
      settle(3);
      expectDelivered("basic", {9'd37, 32'h1111_1111});

      sendKmer(8'h84, 8'h12, 8, -1, 9'd100);
      settle(3);
      expectDelivered("mixed", {9'd100, 32'hB444_4444});

      kmer_ready = 1'b0;
      fork
         begin
            sendKmer(8'h21, 8'h21, 8, -1, 9'd5);
            sendKmer(8'h84, 8'h12, 8, -1, 9'd6);
         end
         begin
            settle(20);
            kmer_ready = 1'b1;
         end
      join
      settle(3);
      checkOutput("bp_count", 41'(delivered.size()), 41'd2);
      if (delivered.size() == 2) begin
         checkOutput("bp_first", delivered[0], {9'd5, 32'h1111_1111});
         checkOutput("bp_second", delivered[1], {9'd6, 32'hB444_4444});
      end
      delivered.delete();

      e_oh0 = n_err_oh;
      sendKmer(8'h21, 8'h21, 8, 3, 9'd11);
      settle(3);
      checkOutput("illegal_err_count", 41'(n_err_oh - e_oh0), 41'd1);
      checkOutput("illegal_no_output", 41'(delivered.size()), 41'd0);
      sendKmer(8'h84, 8'h12, 8, -1, 9'd12);
      settle(3);
      expectDelivered("after_illegal", {9'd12, 32'hB444_4444});

      e_len0 = n_err_len;
      sendKmer(8'h21, 8'h21, 5, -1, 9'd13);
      sendKmer(8'h21, 8'h21, 10, -1, 9'd14);
      settle(3);
      checkOutput("len_err_count", 41'(n_err_len - e_len0), 41'd2);
      checkOutput("len_no_output", 41'(delivered.size()), 41'd0);
      sendKmer(8'h84, 8'h12, 8, -1, 9'd15);
      settle(3);
      expectDelivered("after_len", {9'd15, 32'hB444_4444});

      sendKmer(8'h84, 8'h12, 3, -1, 9'd16);
      sendKmer(8'h21, 8'h21, 3, -1, 9'd17);
      settle(1);
      delivered.delete();
      applyStimulus(8'h84, 9'd18, 1'b0);
      applyStimulus(8'h84, 9'd19, 1'b0);
      applyStimulus(8'h84, 9'd20, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_kmer_valid", 41'(kmer_valid), 41'd0);
      checkOutput("midrst_kmer_data", 41'(kmer_data), 41'd0);
      checkOutput("midrst_kmer_index", 41'(kmer_index), 41'd0);
      checkOutput("midrst_part_ready", 41'(part_ready), 41'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle(1);
      sendKmer(8'h21, 8'h21, 8, -1, 9'd21);
      settle(3);
      expectDelivered("after_reset", {9'd21, 32'h1111_1111});

      gap_max = 2;
      rand_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         nb = ($urandom_range(0, 9) < 7) ? 8 : $urandom_range(1, 11);
         for (int b = 0; b < nb; b++) begin
            d[3:0] = 4'b0001 << $urandom_range(0, 3);
            d[7:4] = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) d[3:0] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110;
            applyStimulus(d, 9'($urandom), b == nb - 1);
         end
      end
      rand_ready = 1'b0;
      kmer_ready = 1'b1;
      settle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
